// File: rtl/mesi_mem_responder.sv
// -----------------------------------------------------------------------------
// mesi_mem_responder
//
// Shared word memory that answers the mem_read / mem_write requests of N
// cache controllers. Requests are arbitrated round-robin. Each granted request
// is serviced with a fixed latency and finishes with a one-cycle one-hot ack
// to the winning cache. For reads, the ack also carries the read data.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (clears the memory as well)
//   mem_read   [N]      per-cache read request, level, held until acked
//   mem_write  [N]      per-cache write request, level, held until acked
//   mem_addr   [N] x32  per-cache byte address
//   mem_wdata  [N] x32  per-cache write data
//   mem_ack    [N]      one-hot completion pulse to the granted cache
//   mem_rdata  32       read data, valid in the read ack cycle, held after
//   busy       1        high while a request is in service (FSM not IDLE)
// -----------------------------------------------------------------------------
module mesi_mem_responder #(
    parameter int N       = 2,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      mem_read,
    input  logic [N-1:0]      mem_write,
    input  logic [31:0]       mem_addr  [N],
    input  logic [31:0]       mem_wdata [N],
    output logic [N-1:0]      mem_ack,
    output logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int GNT_W = $clog2(N);
    // The counter only ever holds LATENCY-1 down to 0.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [GNT_W-1:0]   grant_reg;
    logic [GNT_W-1:0]   last_grant_reg;
    logic               op_write_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [31:0]        wdata_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [31:0]        rdata_reg;
    logic [31:0]        mem_reg [DEPTH];

    logic [N-1:0]       req;
    logic               req_any;
    logic [GNT_W-1:0]   gnt_sel;
    logic [GNT_W-1:0]   cand;

    // A write and a read raised together count as one request. The write
    // takes precedence when the request is latched.
    assign req = mem_read | mem_write;

    // Round-robin search that starts just after the previous winner.
    always_comb begin
        gnt_sel = last_grant_reg;
        req_any = 1'b0;
        cand    = '0;
        for (int off = 1; off <= N; off++) begin
            cand = GNT_W'((int'(last_grant_reg) + off) % N);
            if (!req_any && req[cand]) begin
                gnt_sel = cand;
                req_any = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (req_any) state_next = S_WAIT;
            S_WAIT:  if (cnt_reg == '0) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GNT_W'(N - 1);
            op_write_reg   <= 1'b0;
            idx_reg        <= '0;
            wdata_reg      <= '0;
            cnt_reg        <= '0;
            rdata_reg      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (req_any) begin
                        // Everything needed later is captured here, so the
                        // requester's inputs may change during service.
                        grant_reg      <= gnt_sel;
                        last_grant_reg <= gnt_sel;
                        op_write_reg   <= mem_write[gnt_sel];
                        idx_reg        <= mem_addr[gnt_sel][IDX_W+1:2];
                        wdata_reg      <= mem_wdata[gnt_sel];
                        cnt_reg        <= CNT_W'(LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else if (!op_write_reg) begin
                        // Registered read in the last wait cycle, so the data
                        // is on mem_rdata when the ack is issued.
                        rdata_reg <= mem_reg[idx_reg];
                    end
                end
                S_RESP: begin
                    if (op_write_reg) begin
                        mem_reg[idx_reg] <= wdata_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // The ack is gated by rst so that a reset in the response cycle
    // suppresses the completion pulse.
    for (genvar gi = 0; gi < N; gi++) begin : g_ack
        assign mem_ack[gi] = (state_reg == S_RESP) && !rst &&
                             (grant_reg == GNT_W'(gi));
    end

    assign mem_rdata = rdata_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_mesi_mem_responder.sv
// -----------------------------------------------------------------------------
// Testbench for mesi_mem_responder. The bench pushes the expected acks in the
// order they should be served, and pops them when the DUT acks.
// -----------------------------------------------------------------------------
module tb_mesi_mem_responder;

    localparam int N       = 2;
    localparam int DEPTH   = 16;
    localparam int LATENCY = 2;
    localparam int IDX_W   = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      mem_read;
    logic [N-1:0]      mem_write;
    logic [31:0]       mem_addr  [N];
    logic [31:0]       mem_wdata [N];
    logic [N-1:0]      mem_ack;
    logic [31:0]       mem_rdata;
    logic              busy;

    mesi_mem_responder #(
        .N       (N),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] ack;
        bit           is_read;
        logic [31:0]  rdata;
        int           cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rd;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int word_idx(input logic [31:0] a);
        return int'(a[IDX_W+1:2]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        last_rd = '0;
    endtask

    // Expectations are pushed in service order, so the model sees the same
    // sequence of reads and writes as the memory.
    task automatic expect_rd(input int c, input logic [31:0] addr, input int at);
        exp_t e;
        e.ack     = N'(1 << c);
        e.is_read = 1'b1;
        e.rdata   = model_mem[word_idx(addr)];
        e.cyc     = at;
        last_rd   = e.rdata;
        sb_q.push_back(e);
    endtask

    task automatic expect_wr(input int c, input logic [31:0] addr,
                             input logic [31:0] data, input int at);
        exp_t e;
        e.ack     = N'(1 << c);
        e.is_read = 1'b0;
        e.rdata   = last_rd;   // read data must hold across a write
        e.cyc     = at;
        model_mem[word_idx(addr)] = data;
        sb_q.push_back(e);
    endtask

    // Monitor: every ack is matched against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mem_ack != '0) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_ack", 32'(mem_ack), 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("txn cycle %0d ack %b %s rdata %h", cyc, mem_ack,
                         e.is_read ? "read " : "write", mem_rdata);
                check_val("ack_vec", 32'(mem_ack), 32'(e.ack));
                check_val(e.is_read ? "read_data" : "rdata_hold", mem_rdata, e.rdata);
                check_val("ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int c);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_ack[c]) seen = 1'b1;
        end
        check_val("ack_seen", 32'(seen), 32'd1);
    endtask

    task automatic single_txn(input int c, input bit wr,
                              input logic [31:0] addr, input logic [31:0] data);
        int t0;
        step();
        mem_addr[c]  = addr;
        mem_wdata[c] = data;
        if (wr) mem_write[c] = 1'b1;
        else    mem_read[c]  = 1'b1;
        t0 = cyc;
        if (wr) expect_wr(c, addr, data, t0 + LATENCY + 1);
        else    expect_rd(c, addr, t0 + LATENCY + 1);
        wait_ack(c);
        step();
        mem_read[c]  = 1'b0;
        mem_write[c] = 1'b0;
    endtask

    // Contention agent: take an ack, drop for one cycle, re-request once.
    task automatic agent(input int c);
        for (int n = 0; n < 2; n++) begin
            wait_ack(c);
            step();
            mem_read[c] = 1'b0;
            if (n == 0) begin
                step();
                mem_read[c] = 1'b1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        int t0;
        rst       = 1'b1;
        mem_read  = '0;
        mem_write = '0;
        for (int i = 0; i < N; i++) begin
            mem_addr[i]  = '0;
            mem_wdata[i] = '0;
        end
        model_clear();

        // Reset held two cycles, then five idle cycles.
        for (int k = 0; k < 7; k++) begin
            if (k == 2) begin
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            @(negedge clk);
            check_val("reset_ack", 32'(mem_ack), 32'd0);
            check_val("reset_rdata", mem_rdata, 32'd0);
            check_val("reset_busy", 32'(busy), 32'd0);
        end

        // Single read with busy profile.
        step();
        mem_read[0] = 1'b1;
        mem_addr[0] = 32'h0000_1000;
        t0 = cyc;
        expect_rd(0, 32'h0000_1000, t0 + 3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("busy_single", 32'(busy), 32'(k >= 1));
        end
        step();
        mem_read[0] = 1'b0;
        @(negedge clk);
        check_val("busy_after", 32'(busy), 32'd0);

        // Write from cache1, then a read of the same word from cache0.
        step();
        mem_write[1] = 1'b1;
        mem_addr[1]  = 32'h0000_1000;
        mem_wdata[1] = 32'hDEAD_BEEF;
        t0 = cyc;
        expect_wr(1, 32'h0000_1000, 32'hDEAD_BEEF, t0 + 3);
        step();
        mem_read[0] = 1'b1;
        mem_addr[0] = 32'h0000_1000;
        expect_rd(0, 32'h0000_1000, t0 + 7);
        wait_ack(1);
        step();
        mem_write[1] = 1'b0;
        wait_ack(0);
        step();
        mem_read[0] = 1'b0;

        // Preload two words via cache1. This also makes cache1 the previous winner.
        single_txn(1, 1'b1, 32'h0000_1000, 32'h1111_1111);
        single_txn(1, 1'b1, 32'h0000_1004, 32'h2222_2222);

        // Contention: both caches read continuously for four transactions.
        step();
        mem_addr[0] = 32'h0000_1000;
        mem_addr[1] = 32'h0000_1004;
        mem_read    = 2'b11;
        t0 = cyc;
        expect_rd(0, 32'h0000_1000, t0 + 3);
        expect_rd(1, 32'h0000_1004, t0 + 7);
        expect_rd(0, 32'h0000_1000, t0 + 11);
        expect_rd(1, 32'h0000_1004, t0 + 15);
        fork
            agent(0);
            agent(1);
        join

        // Read and write together from cache0. 0x1040 aliases word 0.
        step();
        mem_addr[0]  = 32'h0000_1040;
        mem_wdata[0] = 32'h1234_5678;
        mem_read[0]  = 1'b1;
        mem_write[0] = 1'b1;
        t0 = cyc;
        expect_wr(0, 32'h0000_1040, 32'h1234_5678, t0 + 3);
        expect_rd(0, 32'h0000_1000, t0 + 7);
        wait_ack(0);
        step();
        mem_write[0] = 1'b0;
        mem_addr[0]  = 32'h0000_1000;
        wait_ack(0);
        step();
        mem_read[0] = 1'b0;

        // Reset while cache1's write is waiting: no ack, and the word stays zero.
        step();
        mem_write[1] = 1'b1;
        mem_addr[1]  = 32'h0000_1008;
        mem_wdata[1] = 32'hA5A5_A5A5;
        step();
        rst          = 1'b1;
        mem_write[1] = 1'b0;
        model_clear();
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("midrst_ack", 32'(mem_ack), 32'd0);
            check_val("midrst_busy", 32'(busy), 32'd0);
            check_val("midrst_rdata", mem_rdata, 32'd0);
        end
        single_txn(0, 1'b0, 32'h0000_1008, 32'h0);

        repeat (3) @(negedge clk);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mesi_mem_responder.md
Name: mesi_mem_responder

Overview:
- Shared-memory responder at the far end of the MESI cache memory interface.
- Services the per-cache mem_read / mem_write requests issued by the N cache controllers in top_system.
- Arbitrates round-robin, models a fixed-latency word memory, and returns a one-cycle ack per request, plus read data for reads.
- Sits below top_system's caches; replaces the implicit "memory always ready" behaviour.

Parameters:
- N, 2, number of requesting caches (>=2).
- DEPTH, 16, number of 32-bit words in backing store (power of 2).
- LATENCY, 2, wait cycles between grant and ack (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  N  per-cache read (line fill) request, level, held until acked.
- mem_write  input  N  per-cache write (writeback) request, level, held until acked.
- mem_addr  input  32 x N (unpacked [N])  per-cache byte address, stable while request high.
- mem_wdata  input  32 x N (unpacked [N])  per-cache write data, stable while mem_write high.
- mem_ack  output  N  one-hot, one-cycle completion pulse to the granted cache.
- mem_rdata  output  32  read data; valid in the ack cycle of a read, held afterwards.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (rst=1 at posedge):
  - mem_ack=0, mem_rdata=0, busy=0, FSM=IDLE.
  - Round-robin pointer last_grant=N-1, so cache 0 wins first.
  - All DEPTH words cleared to 0.
  - Reset wins over every other event.
- Word index = mem_addr[log2(DEPTH)+1:2]. Upper bits and byte offset are ignored, so aliasing wraps modulo DEPTH words.
- Request from cache i = mem_read[i] | mem_write[i]. If both are high, the write is served. The read is a new request only if still high after that ack.
- FSM IDLE:
  - If any request is pending, grant the first requester searching last_grant+1, last_grant+2, … (wrapping mod N).
  - Latch the grant index, op, address and wdata; set last_grant=grant; load wait counter with LATENCY-1; go to WAIT.
  - With no request, stay in IDLE.
- FSM WAIT: decrement the counter each cycle. When the counter is 0, go to RESP.
- FSM RESP (exactly one cycle):
  - mem_ack[grant]=1.
  - Write: memory[idx] <= latched wdata at the end of this cycle.
  - Read: mem_rdata = memory[idx], registered so it is visible in the ack cycle.
  - Next state is IDLE.
- Latency: request first seen in IDLE at cycle 0 gives mem_ack high in cycle LATENCY+1. Back-to-back service gives one ack every LATENCY+2 cycles.
- Requester must deassert in the cycle after its ack. IDLE re-samples in that cycle.
- Inputs changing while granted are ignored, because latched values are used.
- Requests arriving during WAIT/RESP wait their turn; no request is dropped.
- Reset during WAIT or RESP: no ack is issued, no memory write happens, and memory is cleared.
- mem_rdata is unchanged by writes and by idle cycles.

Test Plan:
- Reset:
  - Stimulus: assert rst 2 cycles, idle 5 cycles.
  - Required: mem_ack=0, mem_rdata=0, busy=0 throughout.
- Single read:
  - Stimulus: cache0 mem_read=1, mem_addr=0x1000 at cycle 0 after reset.
  - Required: mem_ack=2'b01 only in cycle 3; mem_rdata=0; busy high cycles 1–3.
- Write then read:
  - Stimulus: cache1 writes 0xDEADBEEF to 0x1000, then cache0 reads 0x1000.
  - Required: cache1 acked first; cache0 ack cycle shows mem_rdata=0xDEADBEEF.
- Contention:
  - Stimulus: both caches hold mem_read to 0x1000/0x1004 simultaneously and re-request after each ack for 4 transactions.
  - Required: acks alternate 01,10,01,10, spaced LATENCY+2=4 cycles.
- Read+write same cache and alias:
  - Stimulus: cache0 raises mem_write (0x1040, 0x12345678) and mem_read together; it drops mem_write after the ack.
  - Required: write served first; the following read of 0x1000 returns 0x12345678 (alias of index 0).
- Reset mid-operation:
  - Stimulus: cache1 write 0xA5A5A5A5 to 0x1008; rst pulsed during WAIT; then cache0 reads 0x1008.
  - Required: no ack for the write; the read returns 0.
